// File: rtl/s838_down_counter.sv
// rtl/s838_down_counter.sv - loadable down counter with terminal-count pulse and auto-reload
// Decrement uses per-group zero flags so the borrow chain is a short AND prefix.
module s838_down_counter #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Clear,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Y,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam int NG = WIDTH / GROUP;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             tc_q, tc_d;

  logic [NG-1:0]    grp_zero;
  logic [NG-1:0]    borrow;
  logic [WIDTH-1:0] y_dec;
  logic             y_zero;
  logic             y_one;

  // Group k decrements only when every lower group is zero.
  genvar g;
  generate
    for (g = 0; g < NG; g++) begin : g_dec
      assign grp_zero[g] = (y_q[g*GROUP +: GROUP] == '0);
      if (g == 0) begin : g_first
        assign borrow[g] = 1'b1;
      end else begin : g_rest
        assign borrow[g] = borrow[g-1] & grp_zero[g-1];
      end
      assign y_dec[g*GROUP +: GROUP] = y_q[g*GROUP +: GROUP] - {{(GROUP-1){1'b0}}, borrow[g]};
    end
  endgenerate

  assign y_zero = &grp_zero;
  assign y_one  = (y_q == WIDTH'(1));

  assign load_ready = (state_q != S_RUN) && !Clear;
  assign Y          = y_q;
  assign tc         = tc_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    r_d     = r_q;
    tc_d    = 1'b0;
    if (Clear) begin
      state_d = S_IDLE;
      y_d     = '0;
      r_d     = '0;
    end else if (load_valid && load_ready) begin
      y_d     = load_data;
      r_d     = load_data;
      state_d = (load_data != '0) ? S_RUN : S_DONE;
    end else if (state_q == S_RUN && enable) begin
      if (y_zero) begin
        y_d = r_q;
      end else begin
        y_d = y_dec;
        if (y_one) begin
          tc_d    = 1'b1;
          state_d = auto_reload ? S_RUN : S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      r_q     <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      r_q     <= r_d;
      tc_q    <= tc_d;
    end
  end

endmodule

// File: doc/s838_down_counter.md
# s838_down_counter

Loadable 32-bit down counter with a synchronous Clear. It is the count-down counterpart of the s838 up-counter state logic. It accepts a start value over a valid/ready load port and decrements on each enabled cycle. It flags the 1→0 transition with a one-cycle terminal-count pulse and either stops or reloads automatically. It sits beside the s838 up-counter, which sources the stimulus, and is used for timeout/period generation in the same benchmark family.

## Interface
Parameters:
- WIDTH, 32, counter width; must be a multiple of GROUP
- GROUP, 8, borrow-lookahead group width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- Clear  input  1  synchronous clear; highest priority after rst_n
- load_valid  input  1  start value offered
- load_data  input  WIDTH  start value
- load_ready  output  1  load can be accepted; combinational: (state != RUN) && !Clear
- enable  input  1  count-step qualifier in RUN
- auto_reload  input  1  sampled at terminal count; 1 = reload and keep running
- Y  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse (registered)
- busy  output  1  state == RUN
- done  output  1  state == DONE

## Operation
- Reset (rst_n=0, async): Y=0, reload register R=0, tc=0, state=IDLE, so busy=0, done=0, load_ready=1.
- States:
  - IDLE: waiting for a first load.
  - RUN: counting.
  - DONE: reached 0 without reload.
- Load: a handshake completes when load_valid && load_ready at a rising edge. It sets Y=load_data and R=load_data.
  - If load_data≠0, the next state is RUN.
  - If load_data==0, the next state is DONE and tc stays 0.
- Loads are accepted in IDLE and DONE only. In RUN, load_valid is ignored and load_ready=0.
- RUN with enable=0: Y, R and state hold; tc=0.
- RUN with enable=1:
  - Y>1: Y←Y−1.
  - Y==1: Y←0 and tc=1 next cycle. If auto_reload=0, state←DONE; else stay in RUN.
  - Y==0: only reachable with auto_reload set. Y←R and tc=0, so the period is R+1 enabled cycles.
- Clear=1: Y←0, R←0, tc←0, state←IDLE, regardless of state, load_valid or enable.
- Decrement datapath:
  - WIDTH/GROUP groups.
  - Each group has a registered-free zero flag (group==0). The borrow into group k is the AND of the zero flags of groups 0..k−1.
  - Result must equal (Y−1) mod 2^WIDTH bit-exactly. Underflow below 0 never occurs because the FSM stops or reloads at 0.
- auto_reload is sampled only at the Y==1 step. Changes at other times have no effect.

## Timing
- All state changes occur on the rising clk edge except reset, which acts immediately.
- Load latency: Y shows load_data and busy=1 in the cycle after the handshake edge.
- tc is high for exactly one cycle: the cycle in which Y first reads 0 after a decrement. tc is never high two consecutive cycles.
- From load of N (N≥1) with enable held high, tc asserts N cycles after the handshake edge.
- A load in DONE the same cycle tc is high is legal. tc still deasserts next cycle.
- A reset assertion mid-RUN aborts the count. The next load after rst_n release behaves as from IDLE.
- Clear and load_valid in the same cycle: Clear wins, the load is not accepted, and load_ready=0 that cycle.

## Test plan
- Reset/idle: assert rst_n=0 mid-count -> Y=0, tc=0, busy=0, done=0, load_ready=1 immediately; after release, idle holds.
- Basic countdown: load 5, enable=1, auto_reload=0 -> Y=5,4,3,2,1,0 on successive cycles; tc=1 only when Y=0; done=1; Y holds 0.
- Group borrow: load 0x0000_0100 with enable pulsed -> next Y=0x0000_00FF. Load 0x0100_0000 -> next Y=0x00FF_FFFF. Load 0xFFFF_FFFF -> next Y=0xFFFF_FFFE.
- Auto-reload with stalls: load 2, auto_reload=1, enable toggling 1,0,1,1,1 -> Y=2,1,1,0(tc),2; busy stays 1; no tc when enable=0.
- Load rules: load_valid in RUN -> ignored and load_ready=0. Load 0 from IDLE -> Y=0, done=1, tc=0. Load 7 in DONE -> RUN, Y=7.
- Clear priority: Clear=1 with load_valid=1 and load_data=9 in IDLE -> load_ready=0, Y stays 0, state IDLE. Clear mid-RUN at Y=3 -> Y=0, busy=0, tc=0.
